// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR    : canonical bubble (addi x0, x0, 0)
//   if_state_e   : fetch controller states
//   is_compressed: true when an instruction word carries an RV32C encoding
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE,
    IF_FETCH,
    IF_DRAIN
  } if_state_e;

  function automatic logic is_compressed(input logic [31:0] instr);
    return instr[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Synchronous prefetch FIFO holding {instr, pc} pairs between the memory
// response port and the IF/ID register.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clear              drop all entries (takes priority over push/pop)
//   push, push_data    write an entry (ignored when full unless popping too)
//   pop, pop_data      consume the head entry; pop_data always shows the head
//   full, empty, count occupancy status
module fetch_fifo
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  // A full FIFO may still accept a write in the same cycle its head leaves.
  assign do_push  = push && (!full || pop) && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign pop_data = mem[rd_ptr];

  // Control: pointers and occupancy (DEPTH is a power of two, pointers wrap)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage: data only, no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage feeding ID_stage.
// Holds the fetch PC, issues word requests on a req/gnt/rvalid memory port,
// buffers in-order responses in a prefetch FIFO and registers {instr, pc,
// valid} into the IF/ID register. A redirect restarts fetch at a new target
// and silently drops responses still owed to the old stream.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   stall / flush              hold / squash the IF/ID register
//   redirect_i, redirect_pc_i  new fetch stream (target forced word-aligned)
//   instr_req_o, instr_addr_o  memory request and word address
//   instr_gnt_i                request accepted
//   instr_rvalid_i, instr_rdata_i  in-order response
//   IF_instr_o, IF_pc_o, IF_valid_o  IF/ID register contents
//   IF_instr_c_illegal_o       registered instruction is a compressed encoding
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic [31:0] IF_instr_o,
  output logic [31:0] IF_pc_o,
  output logic        IF_valid_o,
  output logic        IF_instr_c_illegal_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e      state_q, state_d;
  logic [31:0]    fetch_pc_q;
  logic [31:0]    resp_pc_q;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  discard_q, discard_d;
  logic [31:0]    redirect_target;

  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic [63:0]    fifo_head;

  logic           gnt_acc;
  logic           rvalid_ok;
  logic           drop_resp;
  logic           accept;
  logic           advance;
  logic           bypass;

  // IF/ID register: _p0 is the next value, _p1 the registered copy
  logic [31:0]    instr_p0, instr_p1;
  logic [31:0]    pc_p0, pc_p1;
  logic           vld_p0, vld_p1;
  logic           c_ill_p0, c_ill_p1;

  assign redirect_target = {redirect_pc_i[31:2], 2'b00};

  // Requests are throttled so every owed response has a FIFO slot waiting,
  // and suppressed during a redirect so the new stream starts cleanly.
  assign instr_req_o  = (state_q != IF_IDLE) && !redirect_i &&
                        ((outstanding_q + fifo_count) < CW'(FIFO_DEPTH));
  assign instr_addr_o = fetch_pc_q;

  assign gnt_acc   = instr_req_o && instr_gnt_i;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign rvalid_ok = instr_rvalid_i && (outstanding_q != '0);
  assign drop_resp = rvalid_ok && (discard_q != '0);
  assign accept    = rvalid_ok && (discard_q == '0) && !redirect_i;

  assign outstanding_d = outstanding_q + CW'(gnt_acc) - CW'(rvalid_ok);
  // On redirect everything still in flight belongs to the old stream.
  assign discard_d     = redirect_i ? outstanding_d : (discard_q - CW'(drop_resp));

  assign advance   = !flush && !stall;
  assign fifo_pop  = advance && !redirect_i && !fifo_empty;
  assign bypass    = advance && fifo_empty && accept;
  assign fifo_push = accept && !bypass && (!fifo_full || fifo_pop);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_i),
    .push      (fifo_push),
    .push_data ({instr_rdata_i, resp_pc_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Fetch controller next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_IDLE:  state_d = IF_FETCH;
      IF_FETCH,
      IF_DRAIN: state_d = (discard_d != '0) ? IF_DRAIN : IF_FETCH;
      default:  state_d = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IF_IDLE;
      fetch_pc_q    <= BOOT_ADDR;
      resp_pc_q     <= BOOT_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      if (redirect_i)   fetch_pc_q <= redirect_target;
      else if (gnt_acc) fetch_pc_q <= fetch_pc_q + 32'd4;
      if (redirect_i)   resp_pc_q  <= redirect_target;
      else if (accept)  resp_pc_q  <= resp_pc_q + 32'd4;
    end
  end

  // p0 -> p1: IF/ID register next value (flush > stall > advance)
  always_comb begin
    instr_p0 = instr_p1;
    pc_p0    = pc_p1;
    vld_p0   = vld_p1;
    if (flush) begin
      instr_p0 = NOP_INSTR;
      pc_p0    = '0;
      vld_p0   = 1'b0;
    end else if (!stall) begin
      if (redirect_i) begin
        // Anything queued is on the abandoned path; insert a bubble.
        instr_p0 = NOP_INSTR;
        pc_p0    = '0;
        vld_p0   = 1'b0;
      end else if (!fifo_empty) begin
        instr_p0 = fifo_head[63:32];
        pc_p0    = fifo_head[31:0];
        vld_p0   = 1'b1;
      end else if (accept) begin
        instr_p0 = instr_rdata_i;
        pc_p0    = resp_pc_q;
        vld_p0   = 1'b1;
      end else begin
        instr_p0 = NOP_INSTR;
        pc_p0    = '0;
        vld_p0   = 1'b0;
      end
    end
    c_ill_p0 = vld_p0 && is_compressed(instr_p0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p1 <= NOP_INSTR;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      c_ill_p1 <= 1'b0;
    end else begin
      instr_p1 <= instr_p0;
      pc_p1    <= pc_p0;
      vld_p1   <= vld_p0;
      c_ill_p1 <= c_ill_p0;
    end
  end

  assign IF_instr_o           = instr_p1;
  assign IF_pc_o              = pc_p1;
  assign IF_valid_o           = vld_p1;
  assign IF_instr_c_illegal_o = c_ill_p1;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic [31:0] IF_instr_o;
  logic [31:0] IF_pc_o;
  logic        IF_valid_o;
  logic        IF_instr_c_illegal_o;

  int errors = 0;
  int checks = 0;

  bit gnt_en;
  bit resp_en;
  logic [31:0] pend_q[$];

  if_stage #(
    .BOOT_ADDR  (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stall                (stall),
    .flush                (flush),
    .redirect_i           (redirect_i),
    .redirect_pc_i        (redirect_pc_i),
    .instr_req_o          (instr_req_o),
    .instr_addr_o         (instr_addr_o),
    .instr_gnt_i          (instr_gnt_i),
    .instr_rvalid_i       (instr_rvalid_i),
    .instr_rdata_i        (instr_rdata_i),
    .IF_instr_o           (IF_instr_o),
    .IF_pc_o              (IF_pc_o),
    .IF_valid_o           (IF_valid_o),
    .IF_instr_c_illegal_o (IF_instr_c_illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h200) return 32'h0000_4501;
    if (a == 32'h204) return 32'h00A0_0093;
    return (a << 7) | 32'h0000_0033;
  endfunction

  // Memory: grants when enabled, answers in order no earlier than the
  // cycle after the grant. Driven on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_q.delete();
      instr_gnt_i    = 1'b0;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
    end else begin
      if (resp_en && pend_q.size() > 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = mem_word(pend_q.pop_front());
      end else begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
      end
      instr_gnt_i = gnt_en && instr_req_o;
      if (instr_gnt_i) pend_q.push_back(instr_addr_o);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr"}, IF_instr_o, 32'h0000_0013);
    chk({tag, "_pc"},    IF_pc_o, 32'h0);
    chk({tag, "_valid"}, {31'b0, IF_valid_o}, 32'h0);
    chk({tag, "_cill"},  {31'b0, IF_instr_c_illegal_o}, 32'h0);
    chk({tag, "_req"},   {31'b0, instr_req_o}, 32'h0);
  endtask

  task automatic chk_if(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"},    IF_pc_o, pc);
    chk({tag, "_valid"}, {31'b0, IF_valid_o}, 32'h1);
    chk({tag, "_instr"}, IF_instr_o, mem_word(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0;
    gnt_en = 1'b1; resp_en = 1'b1;

    cyc(); cyc();
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // 1: boot fetch, responses one cycle after grant
    cyc();
    chk("t1_req_c1", {31'b0, instr_req_o}, 32'h1);
    chk("t1_addr_c1", instr_addr_o, 32'h0);
    chk("t1_valid_c1", {31'b0, IF_valid_o}, 32'h0);
    cyc();
    chk("t1_addr_c2", instr_addr_o, 32'h4);
    chk("t1_valid_c2", {31'b0, IF_valid_o}, 32'h0);
    cyc();
    chk_if("t1_c3", 32'h0);
    chk("t1_addr_c3", instr_addr_o, 32'h8);
    cyc(); chk_if("t1_c4", 32'h4);
    cyc(); chk_if("t1_c5", 32'h8);

    // 2: build two outstanding, redirect to 0x103 (aligned to 0x100)
    resp_en = 1'b0;
    cyc();
    chk("t2_req_full", {31'b0, instr_req_o}, 32'h0);
    chk("t2_bubble", {31'b0, IF_valid_o}, 32'h0);
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    #1;
    chk("t2_req_in_redirect", {31'b0, instr_req_o}, 32'h0);
    cyc();
    redirect_i = 1'b0; resp_en = 1'b1;
    chk("t2_valid_r1", {31'b0, IF_valid_o}, 32'h0);
    cyc();
    chk("t2_valid_r2", {31'b0, IF_valid_o}, 32'h0);
    chk("t2_req_new", {31'b0, instr_req_o}, 32'h1);
    chk("t2_addr_new", instr_addr_o, 32'h100);
    cyc();
    chk("t2_valid_r3", {31'b0, IF_valid_o}, 32'h0);
    cyc(); chk_if("t2_first", 32'h100);
    cyc(); chk_if("t2_second", 32'h104);

    // 3: stall four cycles with grants available
    stall = 1'b1;
    cyc(); chk_if("t3_s1", 32'h104);
    cyc(); chk_if("t3_s2", 32'h104);
    chk("t3_req_full", {31'b0, instr_req_o}, 32'h0);
    cyc(); chk_if("t3_s3", 32'h104);
    cyc(); chk_if("t3_s4", 32'h104);
    chk("t3_req_still", {31'b0, instr_req_o}, 32'h0);
    stall = 1'b0;
    cyc(); chk_if("t3_r1", 32'h108);
    chk("t3_req_resume", {31'b0, instr_req_o}, 32'h1);
    chk("t3_addr_resume", instr_addr_o, 32'h110);
    cyc(); chk_if("t3_r2", 32'h10C);
    cyc(); chk_if("t3_r3", 32'h110);

    // 4: flush and stall together with entries queued
    stall = 1'b1;
    cyc(); chk_if("t4_hold", 32'h110);
    flush = 1'b1;
    cyc();
    chk("t4_instr", IF_instr_o, 32'h0000_0013);
    chk("t4_valid", {31'b0, IF_valid_o}, 32'h0);
    chk("t4_pc", IF_pc_o, 32'h0);
    flush = 1'b0; stall = 1'b0;
    cyc(); chk_if("t4_head", 32'h114);
    cyc(); chk_if("t4_next", 32'h118);

    // 5: compressed vs. full-width encodings
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    cyc();
    redirect_i = 1'b0;
    chk("t5_drop_old", {31'b0, IF_valid_o}, 32'h0);
    cyc();
    chk("t5_bubble", {31'b0, IF_valid_o}, 32'h0);
    cyc();
    chk_if("t5_c", 32'h200);
    chk("t5_cill_1", {31'b0, IF_instr_c_illegal_o}, 32'h1);
    cyc();
    chk_if("t5_nc", 32'h204);
    chk("t5_cill_0", {31'b0, IF_instr_c_illegal_o}, 32'h0);

    // 6: asynchronous reset with two outstanding
    resp_en = 1'b0; stall = 1'b1;
    cyc();
    chk("t6_req_full", {31'b0, instr_req_o}, 32'h0);
    chk_if("t6_pre", 32'h204);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("t6_async");
    stall = 1'b0; resp_en = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_req", {31'b0, instr_req_o}, 32'h1);
    chk("t6_addr0", instr_addr_o, 32'h0);
    cyc();
    chk("t6_addr4", instr_addr_o, 32'h4);
    cyc(); chk_if("t6_f0", 32'h0);
    cyc(); chk_if("t6_f4", 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
